// File: rtl/router_pkg.sv
// router_pkg: shared states, widths and header packing for the router packet framer.
package router_pkg;
  localparam int ADDR_W = 2;
  localparam int LEN_W = 6;
  localparam int MAX_LEN = 63;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;
  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;
  function automatic logic [7:0] pack_header(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction
endpackage

// File: rtl/router_pkt_framer_if.sv
// router_pkt_framer_if: request, payload and router-side bus of the framer.
// FRAMER_PARITY_CORRUPT_EN adds the corrupt_parity request qualifier.
interface router_pkt_framer_if #(parameter int CNT_W = 16);
  import router_pkg::*;
  logic req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  logic pl_valid, pl_ready;
  logic [7:0] pl_data;
  logic busy, packet_valid, drop_pulse;
  logic [7:0] pkt_data;
  logic [CNT_W-1:0] pkts_sent;
`ifdef FRAMER_PARITY_CORRUPT_EN
  logic corrupt_parity;
  modport master(
    input req_valid, req_addr, req_len, pl_valid, pl_data, busy, corrupt_parity,
    output req_ready, pl_ready, packet_valid, pkt_data, drop_pulse, pkts_sent
  );
  modport slave(
    output req_valid, req_addr, req_len, pl_valid, pl_data, busy, corrupt_parity,
    input req_ready, pl_ready, packet_valid, pkt_data, drop_pulse, pkts_sent
  );
`else
  modport master(
    input req_valid, req_addr, req_len, pl_valid, pl_data, busy,
    output req_ready, pl_ready, packet_valid, pkt_data, drop_pulse, pkts_sent
  );
  modport slave(
    output req_valid, req_addr, req_len, pl_valid, pl_data, busy,
    input req_ready, pl_ready, packet_valid, pkt_data, drop_pulse, pkts_sent
  );
`endif
endinterface

// File: rtl/router_pkt_framer_buf.sv
// framer_buf: 64x8 payload store with synchronous write and asynchronous read.
module framer_buf
  import router_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [LEN_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);
  logic [7:0] mem [0:MAX_LEN];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/router_pkt_framer.sv
// router_pkt_framer: buffers a payload, then emits header/payload/parity to the router honouring busy.
// FRAMER_PARITY_CORRUPT_EN: a request flagged corrupt_parity gets an inverted parity byte.
module router_pkt_framer
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic resetn,
  router_pkt_framer_if.master bus
);
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] len, wr_cnt, rd_cnt;
  logic [7:0] parity, parity_out, rd_data;
  logic [3:0] gap_cnt;
  logic pl_fire, last_wr;
  assign bus.req_ready = state == IDLE;
  assign bus.pl_ready = state == LOAD;
  assign pl_fire = bus.pl_valid && state == LOAD;
  assign last_wr = wr_cnt == len - LEN_W'(1);
`ifdef FRAMER_PARITY_CORRUPT_EN
  logic corrupt;
  assign parity_out = corrupt ? ~parity : parity;
`else
  assign parity_out = parity;
`endif
  framer_buf u_buf (
    .clk,
    .we(pl_fire),
    .wr_addr(wr_cnt),
    .wr_data(bus.pl_data),
    .rd_addr(rd_cnt),
    .rd_data
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      parity <= '0;
      gap_cnt <= '0;
`ifdef FRAMER_PARITY_CORRUPT_EN
      corrupt <= 1'b0;
`endif
      bus.packet_valid <= 1'b0;
      bus.pkt_data <= '0;
      bus.drop_pulse <= 1'b0;
      bus.pkts_sent <= '0;
    end else begin
      bus.drop_pulse <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          addr <= bus.req_addr;
          len <= bus.req_len;
          parity <= '0;
          wr_cnt <= '0;
`ifdef FRAMER_PARITY_CORRUPT_EN
          corrupt <= bus.corrupt_parity;
`endif
          if (bus.req_addr == INVALID_ADDR || bus.req_len == '0) bus.drop_pulse <= 1'b1;
          else state <= LOAD;
        end
        LOAD: if (bus.pl_valid) begin
          wr_cnt <= wr_cnt + LEN_W'(1);
          parity <= parity ^ bus.pl_data ^ (last_wr ? pack_header(len, addr) : 8'h00);
          if (last_wr) begin
            state <= HEADER;
            rd_cnt <= '0;
            bus.packet_valid <= 1'b1;
            bus.pkt_data <= pack_header(len, addr);
          end
        end
        // rd_cnt is 0 in HEADER and len >= 1, so only PAYLOAD can reach the parity step
        HEADER, PAYLOAD: if (!bus.busy) begin
          if (rd_cnt == len) begin
            state <= PARITY;
            bus.packet_valid <= 1'b0;
            bus.pkt_data <= parity_out;
          end else begin
            state <= PAYLOAD;
            bus.pkt_data <= rd_data;
            rd_cnt <= rd_cnt + LEN_W'(1);
          end
        end
        PARITY: if (!bus.busy) begin
          bus.pkt_data <= '0;
          bus.pkts_sent <= bus.pkts_sent + CNT_W'(1);
          gap_cnt <= '0;
          state <= GAP_CYCLES == 0 ? IDLE : GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
          if (gap_cnt == 4'(GAP_CYCLES - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
